lpa_left_feeder: RTL and testbench

//  Transmit side of the LinearProcessingArray left (operand-0) interface.
//  - Accepts one row-major AXI-Stream of operand-0 words.
//  - Builds complete rows of PE_NUMBER_J words in a staging register.
//  - Pushes each row into PE_NUMBER_J per-lane FIFOs in the same cycle, so all left lanes stay row-aligned.
//  - Drives the array's s_axis_left_* bundle.

---
 rtl/lpa_left_feeder_if.sv | 25 ++
 rtl/lpa_left_feeder.sv | 150 +++++++++++++++
 tb/tb_lpa_left_feeder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lpa_left_feeder_if.sv
// Stream bundle between the operand-0 source, the left feeder and the
// array's per-lane left inputs.
interface lpa_left_feeder_if #(
   parameter int PE_NUMBER_J    = 4,
   parameter int DATA_WIDTH_OP0 = 16
);
   logic [DATA_WIDTH_OP0-1:0]             s_axis_tdata;
   logic                                  s_axis_tvalid;
   logic                                  s_axis_tready;
   logic                                  s_axis_tlast;
   logic [PE_NUMBER_J*DATA_WIDTH_OP0-1:0] m_axis_left_tdata;
   logic [PE_NUMBER_J-1:0]                m_axis_left_tvalid;
   logic [PE_NUMBER_J-1:0]                m_axis_left_tready;
   logic [PE_NUMBER_J-1:0]                m_axis_left_tlast;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_left_tready,
      output s_axis_tready, m_axis_left_tdata, m_axis_left_tvalid, m_axis_left_tlast
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_left_tready,
      input  s_axis_tready, m_axis_left_tdata, m_axis_left_tvalid, m_axis_left_tlast
   );
endinterface

// File: rtl/lpa_left_feeder.sv
// Left (operand-0) feeder: stages one row, then writes it into all lane FIFOs at once.
// Define LPA_FEEDER_ZERO_PAD_EN to zero-pad and forward partial rows instead of dropping them.
module lpa_left_feeder #(
   parameter int PE_NUMBER_J    = 4,
   parameter int DATA_WIDTH_OP0 = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic              clk,
   input  logic              rst,
   lpa_left_feeder_if.slave  bus,
   output logic              err_partial_row
);
   localparam int PW = (PE_NUMBER_J > 1) ? $clog2(PE_NUMBER_J) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = DATA_WIDTH_OP0;

   typedef enum logic {FILL, PUSH} state_t;

   state_t                 r_state;
   state_t                 w_nextState;
   logic                   w_sReady;
   logic                   w_accept;
   logic                   w_rowEnd;
   logic                   w_partial;
   logic                   w_push;
   logic                   w_lastLane;
   logic [PW-1:0]          r_lanePtr;
   logic [DW-1:0]          r_stage [PE_NUMBER_J];
   logic                   r_rowLast;
   logic                   r_err;

   logic [DW-1:0]          r_mem     [PE_NUMBER_J][FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]  r_memLast [PE_NUMBER_J];
   logic [AW-1:0]          r_wPtr    [PE_NUMBER_J];
   logic [AW-1:0]          r_rPtr    [PE_NUMBER_J];
   logic [CW-1:0]          r_count   [PE_NUMBER_J];
   logic [PE_NUMBER_J-1:0] w_pop;
   logic [PE_NUMBER_J-1:0] w_space;

   assign w_lastLane         = (r_lanePtr == PW'(PE_NUMBER_J - 1));
   assign bus.s_axis_tready  = w_sReady & rst;
   assign err_partial_row    = r_err;

   always_comb begin
      for (int j = 0; j < PE_NUMBER_J; j++) begin
         w_pop[j]   = bus.m_axis_left_tvalid[j] & bus.m_axis_left_tready[j];
         w_space[j] = (r_count[j] < CW'(FIFO_DEPTH)) | w_pop[j];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= FILL;
      else      r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_sReady    = 1'b0;
      w_accept    = 1'b0;
      w_rowEnd    = 1'b0;
      w_partial   = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         FILL: begin
            w_sReady = 1'b1;
            w_accept = bus.s_axis_tvalid;
            if (w_accept) begin
               w_rowEnd  = w_lastLane | bus.s_axis_tlast;
               w_partial = bus.s_axis_tlast & ~w_lastLane;
`ifdef LPA_FEEDER_ZERO_PAD_EN
               if (w_rowEnd) w_nextState = PUSH;
`else
               // A truncated row is discarded here and never reaches the lanes.
               if (w_rowEnd && !w_partial) w_nextState = PUSH;
`endif
            end
         end
         PUSH: begin
            if (&w_space) begin
               w_push      = 1'b1;
               w_nextState = FILL;
            end
         end
         default: w_nextState = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lanePtr <= '0;
         r_rowLast <= 1'b0;
         r_err     <= 1'b0;
         for (int j = 0; j < PE_NUMBER_J; j++) r_stage[j] <= '0;
      end else if (w_accept) begin
         r_stage[r_lanePtr] <= bus.s_axis_tdata;
         if (w_rowEnd) begin
            r_lanePtr <= '0;
            r_rowLast <= bus.s_axis_tlast;
         end else begin
            r_lanePtr <= r_lanePtr + 1'b1;
         end
         if (w_partial) begin
            r_err <= 1'b1;
`ifdef LPA_FEEDER_ZERO_PAD_EN
            for (int j = 0; j < PE_NUMBER_J; j++)
               if (j > int'(r_lanePtr)) r_stage[j] <= '0;
`endif
         end
      end
   end

   // Storage is not reset; emptying the pointers is enough to discard it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int j = 0; j < PE_NUMBER_J; j++) begin
            r_mem[j][r_wPtr[j]]     <= r_stage[j];
            r_memLast[j][r_wPtr[j]] <= r_rowLast;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int j = 0; j < PE_NUMBER_J; j++) begin
            r_wPtr[j]  <= '0;
            r_rPtr[j]  <= '0;
            r_count[j] <= '0;
         end
      end else begin
         for (int j = 0; j < PE_NUMBER_J; j++) begin
            if (w_push)   r_wPtr[j] <= r_wPtr[j] + 1'b1;
            if (w_pop[j]) r_rPtr[j] <= r_rPtr[j] + 1'b1;
            case ({w_push, w_pop[j]})
               2'b10:   r_count[j] <= r_count[j] + 1'b1;
               2'b01:   r_count[j] <= r_count[j] - 1'b1;
               default: r_count[j] <= r_count[j];
            endcase
         end
      end
   end

   always_comb begin
      for (int j = 0; j < PE_NUMBER_J; j++) begin
         bus.m_axis_left_tdata[j*DW +: DW] = r_mem[j][r_rPtr[j]];
         bus.m_axis_left_tvalid[j]         = (r_count[j] != '0);
         bus.m_axis_left_tlast[j]          = r_memLast[j][r_rPtr[j]];
      end
   end
endmodule

// File: tb/tb_lpa_left_feeder.sv
// Randomized and directed bench for lpa_left_feeder against a row-level
// queue model of what each lane must emit.
module tb_lpa_left_feeder;
   localparam int J     = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic err;
   logic [J-1:0] readySet   = '0;
   logic [J-1:0] randReady  = '0;
   bit           randomReady = 1'b0;

   int checkCount  = 0;
   int errorCount  = 0;

   logic [DW:0]   expQ [J][$];
   logic [DW-1:0] rowBuf[$];
   bit            errExp = 1'b0;

   always #5 clk = ~clk;

   lpa_left_feeder_if #(.PE_NUMBER_J(J), .DATA_WIDTH_OP0(DW)) bus ();

   lpa_left_feeder #(.PE_NUMBER_J(J), .DATA_WIDTH_OP0(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus.slave),
      .err_partial_row (err)
   );

   assign bus.m_axis_left_tready = randomReady ? randReady : readySet;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Row-level reference: a complete row goes to every lane; a truncated one
   // is padded with zeros and marked last, or dropped, depending on the build.
   task automatic modelAccept(input logic [DW-1:0] d, input bit l);
      rowBuf.push_back(d);
      if (l || rowBuf.size() == J) begin
         if (rowBuf.size() == J) begin
            for (int j = 0; j < J; j++) expQ[j].push_back({l, rowBuf[j]});
         end else begin
            errExp = 1'b1;
`ifdef LPA_FEEDER_ZERO_PAD_EN
            for (int j = 0; j < J; j++)
               expQ[j].push_back({1'b1, (j < rowBuf.size()) ? rowBuf[j] : {DW{1'b0}}});
`endif
         end
         rowBuf.delete();
      end
   endtask

   function automatic int pendingWords();
      int n = 0;
      for (int j = 0; j < J; j++) n += expQ[j].size();
      return n;
   endfunction

   always @(posedge clk) begin
      #1;
      randReady = J'($urandom);
   end

   // Sample at the falling edge: scoreboard lane pops, feed accepted words to the model.
   always @(negedge clk) begin : monitor
      logic [DW:0] e;
      if (!rst) begin
         for (int j = 0; j < J; j++) expQ[j].delete();
         rowBuf.delete();
         errExp = 1'b0;
      end else begin
         checkOutput("err_flag", err, errExp);
         for (int j = 0; j < J; j++) begin
            if (bus.m_axis_left_tvalid[j] && bus.m_axis_left_tready[j]) begin
               if (expQ[j].size() == 0) begin
                  checkOutput($sformatf("lane%0d_spurious", j), 1, 0);
               end else begin
                  e = expQ[j].pop_front();
                  checkOutput($sformatf("lane%0d_data", j), bus.m_axis_left_tdata[j*DW +: DW], e[DW-1:0]);
                  checkOutput($sformatf("lane%0d_last", j), bus.m_axis_left_tlast[j], e[DW]);
               end
            end
         end
         if (bus.s_axis_tvalid && bus.s_axis_tready)
            modelAccept(bus.s_axis_tdata, bus.s_axis_tlast);
      end
   end

   task automatic applyStimulus(input logic [DW-1:0] d, input bit l);
      int n = 0;
      @(posedge clk); #1;
      bus.s_axis_tdata  = d;
      bus.s_axis_tlast  = l;
      bus.s_axis_tvalid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.s_axis_tready && n < 300);
      if (!bus.s_axis_tready) begin
         checkOutput("input_handshake_timeout", 0, 1);
         bus.s_axis_tvalid = 1'b0;
      end else begin
         @(posedge clk); #1;
         bus.s_axis_tvalid = 1'b0;
         bus.s_axis_tlast  = 1'b0;
      end
   endtask

   task automatic sendWords(input int first, input int n, input bit lastOnEnd);
      for (int i = 0; i < n; i++) applyStimulus(DW'(first + i), lastOnEnd && (i == n - 1));
   endtask

   task automatic waitDrain(input string tag);
      int n = 0;
      while (pendingWords() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, pendingWords(), 0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_tvalid"}, bus.m_axis_left_tvalid, 0);
      checkOutput({tag, "_err"}, err, 0);
      checkOutput({tag, "_tready"}, bus.s_axis_tready, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.s_axis_tdata  = '0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;

      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      $display("[TB] test 1: two full rows");
      readySet = '1;
      sendWords(1, 8, 1'b1);
      waitDrain("t1_drain");
      checkOutput("t1_err", err, 0);

      $display("[TB] test 2: backpressure until five rows are held");
      readySet = '0;
      sendWords(101, 20, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("t2_stall_tready", bus.s_axis_tready, 0);
      checkOutput("t2_tvalid_all", bus.m_axis_left_tvalid, {J{1'b1}});
      @(posedge clk); #1;
      readySet = '1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t2_push_next_cycle", bus.s_axis_tready, 1);
      checkOutput("t2_tvalid_full", bus.m_axis_left_tvalid, {J{1'b1}});
      waitDrain("t2_drain");

      $display("[TB] test 3: truncated row");
      sendWords(1, 6, 1'b1);
      waitDrain("t3_drain");
      checkOutput("t3_err_sticky", err, 1);

      $display("[TB] test 4: reset mid-row");
      sendWords(9, 2, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("t4_reset");
      @(posedge clk); #1;
      rst = 1'b1;
      sendWords(9, 4, 1'b1);
      waitDrain("t4_drain");
      checkOutput("t4_err_cleared", err, 0);

      $display("[TB] test 5: only lane 0 ready");
      readySet = {{(J-1){1'b0}}, 1'b1};
      sendWords(201, 20, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("t5_stall_tready", bus.s_axis_tready, 0);
      checkOutput("t5_tvalid", bus.m_axis_left_tvalid, {{(J-1){1'b1}}, 1'b0});
      @(posedge clk); #1;
      readySet = '1;
      waitDrain("t5_drain");

      $display("[TB] test 6: push into full lanes that pop in the same cycle");
      readySet = '0;
      sendWords(301, 20, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("t6_stall_tready", bus.s_axis_tready, 0);
      @(posedge clk); #1;
      readySet = '1;
      @(posedge clk); #1;
      readySet = '0;
      @(negedge clk);
      checkOutput("t6_push_accepted", bus.s_axis_tready, 1);
      checkOutput("t6_tvalid_full", bus.m_axis_left_tvalid, {J{1'b1}});
      sendWords(321, 4, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("t6_count_stays_full", bus.s_axis_tready, 0);
      @(posedge clk); #1;
      readySet = '1;
      waitDrain("t6_drain");

      $display("[TB] random phase");
      randomReady = 1'b1;
      for (int i = 0; i < 120; i++)
         applyStimulus(DW'($urandom), ($urandom_range(0, 5) == 0));
      sendWords(401, J, 1'b1);
      randomReady = 1'b0;
      readySet    = '1;
      waitDrain("random_drain");

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
